sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Pixel stage directly downstream of sync_generator. Consumes hsync, vsync, display_on, screen_hpos, screen_vpos and frame_end, and produces 6-bit RGB for the VGA PMOD with sync delayed to match.
- Composites one 8x8 1-bit sprite, scaled by 2^SCALE, over a flat background colour.
- Sprite position, colour, mirror and enable arrive from game logic over a valid/ready handshake. They are staged in a shadow register and committed only at frame_end, so there is no tearing.

Parameters:
- SCALE, 1, log2 pixel-replication factor; sprite is (8<<SCALE) pixels square, 16x16 by default; legal values 0..3.
- BG_COLOR, 6'b000001, background RGB222 {R[1:0],G[1:0],B[1:0]} during active video.

Ports:
- clk  in  1  system clock, one pixel per cycle
- reset  in  1  synchronous, active-high reset
- hsync_in  in  1  hsync from sync_generator
- vsync_in  in  1  vsync from sync_generator
- display_on  in  1  active-video flag from sync_generator
- screen_hpos  in  10  current pixel x
- screen_vpos  in  10  current pixel y
- frame_end  in  1  single-cycle end-of-frame pulse
- upd_valid  in  1  update request
- upd_ready  out  1  shadow register free
- upd_x  in  10  sprite left edge
- upd_y  in  10  sprite top edge
- upd_color  in  6  sprite RGB222
- upd_mirror  in  1  horizontal flip
- upd_enable  in  1  draw sprite when 1
- hsync  out  1  hsync_in delayed 2 cycles
- vsync  out  1  vsync_in delayed 2 cycles
- rgb  out  6  pixel colour {R,G,B}
- sprite_hit  out  1  1 when the current output pixel is a sprite-opaque pixel

Behaviour:
- Reset:
  - rgb=0, hsync=0, vsync=0, sprite_hit=0, upd_ready=1.
  - FSM=IDLE, shadow discarded.
  - Active sprite: x=0, y=0, color=0, mirror=0, enable=0.
  - Pipeline flushes within 2 cycles of reset release.
  - Reset mid-operation drops any pending update.
- Update FSM:
  - IDLE: upd_ready=1. On upd_valid, capture upd_* into the shadow register and go to PENDING; upd_ready=0 from the next cycle.
  - PENDING: upd_ready=0, upd_valid ignored. On frame_end, copy shadow to active registers and return to IDLE; upd_ready=1 the next cycle.
  - An update accepted in the same cycle as frame_end, from IDLE, is NOT committed. It waits for the following frame_end.
  - Active registers change only on the commit edge, so a frame never mixes old and new sprite state.
- Pixel pipeline, latency exactly 2 cycles for all outputs:
  - Stage 1 registers:
    - in_x = screen_hpos >= x and screen_hpos < x + (8<<SCALE)
    - in_y likewise for screen_vpos
    - col = (screen_hpos - x) >> SCALE, row = (screen_vpos - y) >> SCALE, both 3-bit
    - display_on, hsync_in and vsync_in
  - Bounds arithmetic is 11-bit unsigned, so x + width overflowing 10 bits clips at the right/bottom edge and never wraps to column/row 0.
  - Stage 2: bit index b = mirror ? col : 7-col, opaque = ROM[row][b] & in_x & in_y & enable.
    - rgb = !display_on_d ? 0 : opaque ? color : BG_COLOR.
    - sprite_hit = opaque & display_on_d.
- ROM, bit7 = leftmost column, rows 0..7: 80, C0, E0, F0, F0, E0, C0, 80 (hex); a right-pointing triangle.
- Sync passthrough is delayed with no inversion or modification.
- Blanking: rgb=0 and sprite_hit=0 regardless of sprite state.

Test Plan:
- Reset, then hold reset 3 cycles with display_on=1 -> rgb=0, hsync=0, upd_ready=1; after release with no update, active pixels show rgb=6'b000001.
- Update x=100, y=50, color=6'b110000, enable=1, then drive frame_end.
  - Pixel (100,50) -> 6'b110000 two cycles later.
  - Pixel (102,50) (col1, row0 bit6=0) -> 6'b000001.
  - Pixel (106,56) (col3, row3=F0) -> 6'b110000.
- Same sprite with mirror=1 -> pixel (114,50) gives 6'b110000 and pixel (100,50) gives 6'b000001.
- Handshake:
  - Update accepted -> upd_ready=0 next cycle.
  - A second upd_valid while PENDING is ignored.
  - Update accepted in the frame_end cycle -> old sprite still drawn for a full frame; new sprite appears after the next frame_end.
- Edge clip: x=632, y=0 -> pixels 632..639 may show sprite; pixel x=0 on rows 0..15 shows background only.
- Timing: toggle hsync_in/vsync_in -> hsync/vsync follow exactly 2 cycles later; display_on=0 -> rgb=0 even inside sprite bounds.

Source files
------------

// File: rtl/sprite_compositor.sv
// Pixel stage after the sync generator: draws one scaled 8x8 1-bit sprite over
// a flat background. Sprite updates are staged and committed only at frame_end.
module sprite_compositor #(
  parameter int          SCALE    = 1,
  parameter logic [5:0]  BG_COLOR = 6'b000001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        display_on,
  input  logic [9:0]  screen_hpos,
  input  logic [9:0]  screen_vpos,
  input  logic        frame_end,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [9:0]  upd_x,
  input  logic [9:0]  upd_y,
  input  logic [5:0]  upd_color,
  input  logic        upd_mirror,
  input  logic        upd_enable,
  output logic        hsync,
  output logic        vsync,
  output logic [5:0]  rgb,
  output logic        sprite_hit
);

  localparam logic [10:0] SPRITE_W = 11'(8 << SCALE);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t state_reg, state_next;
  logic   shadow_load;
  logic   commit;

  logic [9:0] shadow_x_reg, shadow_y_reg;
  logic [5:0] shadow_color_reg;
  logic       shadow_mirror_reg, shadow_enable_reg;

  logic [9:0] active_x_reg, active_y_reg;
  logic [5:0] active_color_reg;
  logic       active_mirror_reg, active_enable_reg;

  // ---------------------------------------------------------------- update FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // An update accepted in IDLE never commits in the same cycle, even if
  // frame_end is high then; it waits in PENDING for the next frame_end.
  always_comb begin
    state_next  = state_reg;
    shadow_load = 1'b0;
    commit      = 1'b0;
    upd_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        upd_ready = 1'b1;
        if (upd_valid) begin
          shadow_load = 1'b1;
          state_next  = PENDING;
        end
      end
      PENDING: begin
        if (frame_end) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_x_reg      <= '0;
      shadow_y_reg      <= '0;
      shadow_color_reg  <= '0;
      shadow_mirror_reg <= 1'b0;
      shadow_enable_reg <= 1'b0;
    end else if (shadow_load) begin
      shadow_x_reg      <= upd_x;
      shadow_y_reg      <= upd_y;
      shadow_color_reg  <= upd_color;
      shadow_mirror_reg <= upd_mirror;
      shadow_enable_reg <= upd_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_x_reg      <= '0;
      active_y_reg      <= '0;
      active_color_reg  <= '0;
      active_mirror_reg <= 1'b0;
      active_enable_reg <= 1'b0;
    end else if (commit) begin
      active_x_reg      <= shadow_x_reg;
      active_y_reg      <= shadow_y_reg;
      active_color_reg  <= shadow_color_reg;
      active_mirror_reg <= shadow_mirror_reg;
      active_enable_reg <= shadow_enable_reg;
    end
  end

  // ---------------------------------------------------------------- stage 1
  // 11-bit arithmetic so a sprite hanging off the right/bottom edge clips
  // instead of wrapping around to column/row 0.
  logic [10:0] h_ext, v_ext, x_ext, y_ext;
  logic [10:0] dx, dy, dx_scaled, dy_scaled;
  logic        in_x, in_y;

  assign h_ext     = {1'b0, screen_hpos};
  assign v_ext     = {1'b0, screen_vpos};
  assign x_ext     = {1'b0, active_x_reg};
  assign y_ext     = {1'b0, active_y_reg};
  assign dx        = h_ext - x_ext;
  assign dy        = v_ext - y_ext;
  assign dx_scaled = dx >> SCALE;
  assign dy_scaled = dy >> SCALE;
  assign in_x      = (h_ext >= x_ext) && (h_ext < (x_ext + SPRITE_W));
  assign in_y      = (v_ext >= y_ext) && (v_ext < (y_ext + SPRITE_W));

  logic       in_x_reg, in_y_reg;
  logic [2:0] col_reg, row_reg;
  logic       disp_d1_reg, hsync_d1_reg, vsync_d1_reg;
  logic [5:0] color_d1_reg;
  logic       mirror_d1_reg, enable_d1_reg;

  // Sprite attributes travel with the pixel so both stages see one state.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_x_reg      <= 1'b0;
      in_y_reg      <= 1'b0;
      col_reg       <= '0;
      row_reg       <= '0;
      disp_d1_reg   <= 1'b0;
      hsync_d1_reg  <= 1'b0;
      vsync_d1_reg  <= 1'b0;
      color_d1_reg  <= '0;
      mirror_d1_reg <= 1'b0;
      enable_d1_reg <= 1'b0;
    end else begin
      in_x_reg      <= in_x;
      in_y_reg      <= in_y;
      col_reg       <= dx_scaled[2:0];
      row_reg       <= dy_scaled[2:0];
      disp_d1_reg   <= display_on;
      hsync_d1_reg  <= hsync_in;
      vsync_d1_reg  <= vsync_in;
      color_d1_reg  <= active_color_reg;
      mirror_d1_reg <= active_mirror_reg;
      enable_d1_reg <= active_enable_reg;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [7:0] rom_row;
  logic [2:0] bit_idx;
  logic       opaque;

  // Right-pointing triangle, bit 7 is the leftmost column.
  always_comb begin
    rom_row = 8'h00;
    case (row_reg)
      3'd0: rom_row = 8'h80;
      3'd1: rom_row = 8'hC0;
      3'd2: rom_row = 8'hE0;
      3'd3: rom_row = 8'hF0;
      3'd4: rom_row = 8'hF0;
      3'd5: rom_row = 8'hE0;
      3'd6: rom_row = 8'hC0;
      3'd7: rom_row = 8'h80;
      default: rom_row = 8'h00;
    endcase
  end

  assign bit_idx = mirror_d1_reg ? col_reg : (3'd7 - col_reg);
  assign opaque  = rom_row[bit_idx] & in_x_reg & in_y_reg & enable_d1_reg;

  logic [5:0] rgb_reg;
  logic       hit_reg, hsync_d2_reg, vsync_d2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_reg      <= '0;
      hit_reg      <= 1'b0;
      hsync_d2_reg <= 1'b0;
      vsync_d2_reg <= 1'b0;
    end else begin
      rgb_reg      <= !disp_d1_reg ? 6'd0 : (opaque ? color_d1_reg : BG_COLOR);
      hit_reg      <= opaque & disp_d1_reg;
      hsync_d2_reg <= hsync_d1_reg;
      vsync_d2_reg <= vsync_d1_reg;
    end
  end

  assign rgb        = rgb_reg;
  assign sprite_hit = hit_reg;
  assign hsync      = hsync_d2_reg;
  assign vsync      = vsync_d2_reg;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: reset, drawing, mirror, handshake,
// commit timing, edge clipping and sync/blanking latency.
module tb_sprite_compositor;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync_in, vsync_in, display_on;
  logic [9:0] screen_hpos, screen_vpos;
  logic       frame_end;
  logic       upd_valid;
  logic       upd_ready;
  logic [9:0] upd_x, upd_y;
  logic [5:0] upd_color;
  logic       upd_mirror, upd_enable;
  logic       hsync, vsync;
  logic [5:0] rgb;
  logic       sprite_hit;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [5:0] BG  = 6'b000001;
  localparam logic [5:0] RED = 6'b110000;
  localparam logic [5:0] GRN = 6'b001100;

  sprite_compositor #(.SCALE(1), .BG_COLOR(6'b000001)) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .display_on  (display_on),
    .screen_hpos (screen_hpos),
    .screen_vpos (screen_vpos),
    .frame_end   (frame_end),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_x       (upd_x),
    .upd_y       (upd_y),
    .upd_color   (upd_color),
    .upd_mirror  (upd_mirror),
    .upd_enable  (upd_enable),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .sprite_hit  (sprite_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel and check the output two cycles later.
  task automatic pixel(input string tag, input int x, input int y, input logic don,
                       input logic [5:0] exp_rgb, input logic exp_hit);
    screen_hpos = 10'(x);
    screen_vpos = 10'(y);
    display_on  = don;
    tick();
    tick();
    $display("pixel %s (%0d,%0d) rgb=%b hit=%0b", tag, x, y, rgb, sprite_hit);
    check({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
    check({tag, "_hit"}, 32'(sprite_hit), 32'(exp_hit));
  endtask

  task automatic set_upd(input int x, input int y, input logic [5:0] c,
                         input logic m, input logic e);
    upd_x      = 10'(x);
    upd_y      = 10'(y);
    upd_color  = c;
    upd_mirror = m;
    upd_enable = e;
    upd_valid  = 1'b1;
  endtask

  task automatic send_update(input int x, input int y, input logic [5:0] c,
                             input logic m, input logic e);
    set_upd(x, y, c, m, e);
    tick();
    upd_valid = 1'b0;
    $display("update x=%0d y=%0d color=%b mirror=%0b enable=%0b ready=%0b", x, y, c, m, e, upd_ready);
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    $display("frame_end ready=%0b", upd_ready);
  endtask

  initial begin
    reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; display_on = 1'b1;
    screen_hpos = 10'd10; screen_vpos = 10'd10; frame_end = 1'b0;
    upd_valid = 1'b0; upd_x = '0; upd_y = '0; upd_color = '0;
    upd_mirror = 1'b0; upd_enable = 1'b0;

    // Reset held 3 cycles with display active
    tick(); tick(); tick();
    $display("reset rgb=%b hsync=%0b vsync=%0b ready=%0b", rgb, hsync, vsync, upd_ready);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_ready", 32'(upd_ready), 32'd1);
    check("rst_hit", 32'(sprite_hit), 32'd0);
    reset = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    tick(); tick();
    pixel("bg_idle", 10, 10, 1'b1, BG, 1'b0);

    // Basic draw
    send_update(100, 50, RED, 1'b0, 1'b1);
    check("accept_ready", 32'(upd_ready), 32'd0);
    pixel("precommit", 100, 50, 1'b1, BG, 1'b0);
    pulse_frame_end();
    check("commit_ready", 32'(upd_ready), 32'd1);
    pixel("p100_50", 100, 50, 1'b1, RED, 1'b1);
    pixel("p102_50", 102, 50, 1'b1, BG, 1'b0);
    pixel("p106_56", 106, 56, 1'b1, RED, 1'b1);
    pixel("p99_50", 99, 50, 1'b1, BG, 1'b0);
    pixel("p100_66", 100, 66, 1'b1, BG, 1'b0);

    // Mirrored
    send_update(100, 50, RED, 1'b1, 1'b1);
    pulse_frame_end();
    pixel("mir114", 114, 50, 1'b1, RED, 1'b1);
    pixel("mir100", 100, 50, 1'b1, BG, 1'b0);
    pixel("mir116", 116, 50, 1'b1, BG, 1'b0);

    // Second request while PENDING is ignored
    send_update(100, 50, RED, 1'b0, 1'b1);
    set_upd(300, 50, RED, 1'b0, 1'b1);
    tick();
    upd_valid = 1'b0;
    check("pend_ready", 32'(upd_ready), 32'd0);
    pulse_frame_end();
    pixel("ign100", 100, 50, 1'b1, RED, 1'b1);
    pixel("ign300", 300, 50, 1'b1, BG, 1'b0);

    // Update accepted in the frame_end cycle waits a whole frame
    set_upd(200, 50, RED, 1'b0, 1'b1);
    frame_end = 1'b1;
    tick();
    upd_valid = 1'b0; frame_end = 1'b0;
    check("same_ready", 32'(upd_ready), 32'd0);
    pixel("same_old", 100, 50, 1'b1, RED, 1'b1);
    pixel("same_new", 200, 50, 1'b1, BG, 1'b0);
    pulse_frame_end();
    pixel("next_new", 200, 50, 1'b1, RED, 1'b1);
    pixel("next_old", 100, 50, 1'b1, BG, 1'b0);

    // Right-edge clipping must not wrap to column 0
    send_update(632, 0, GRN, 1'b0, 1'b1);
    pulse_frame_end();
    pixel("clip632", 632, 0, 1'b1, GRN, 1'b1);
    pixel("clip633_1", 633, 1, 1'b1, GRN, 1'b1);
    pixel("clip0_0", 0, 0, 1'b1, BG, 1'b0);
    pixel("clip0_15", 0, 15, 1'b1, BG, 1'b0);
    pixel("clip1_7", 1, 7, 1'b1, BG, 1'b0);

    // Sync delay of exactly two cycles
    hsync_in = 1'b1;
    tick();
    check("hs_d1", 32'(hsync), 32'd0);
    tick();
    check("hs_d2", 32'(hsync), 32'd1);
    hsync_in = 1'b0; vsync_in = 1'b1;
    tick();
    check("vs_d1", 32'(vsync), 32'd0);
    check("hs_d1_fall", 32'(hsync), 32'd1);
    tick();
    check("vs_d2", 32'(vsync), 32'd1);
    check("hs_d2_fall", 32'(hsync), 32'd0);
    vsync_in = 1'b0;
    $display("sync hsync=%0b vsync=%0b", hsync, vsync);

    // Blanking inside sprite bounds
    pixel("blank", 632, 0, 1'b0, 6'd0, 1'b0);

    // Reset while PENDING drops the update and clears the active sprite
    send_update(10, 10, 6'b111111, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_ready", 32'(upd_ready), 32'd1);
    pulse_frame_end();
    pixel("rst_drop", 10, 10, 1'b1, BG, 1'b0);
    pixel("rst_clear", 632, 0, 1'b1, BG, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
